// File: rtl/lock_pkg.sv
// Shared definitions for the keypad lock blocks: dialer and lock state
// encodings, digit width and the factory default code digits.
package lock_pkg;

    localparam int DIGIT_W = 4;

    localparam logic [DIGIT_W-1:0] DEFAULT_DIGIT_1 = 4'h2;
    localparam logic [DIGIT_W-1:0] DEFAULT_DIGIT_2 = 4'h3;

    // Dialer FSM encoding; RETRY is only reachable when retries are built in,
    // otherwise codes 5-7 fall back to IDLE.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SEND  = 3'd1,
        GAP   = 3'd2,
        WAIT  = 3'd3,
        DONE  = 3'd4,
        RETRY = 3'd5
    } dialer_state_t;

    // Encoding used by the combination-lock block on the other side.
    typedef enum logic [2:0] {
        LOCKED = 3'd0,
        OK     = 3'd1,
        BAD1   = 3'd2,
        BAD2   = 3'd3,
        OPEN   = 3'd4
    } lock_state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/lock_dialer_if.sv
// Dialer <-> lock connection: digit/strobe toward the lock, Open/Fail back.
// LockReset exists only when LOCK_DIALER_RETRY_EN is defined.
interface lock_dialer_if;
    logic [lock_pkg::DIGIT_W-1:0] Digit;
    logic                         Enter;
    logic                         LockOpen;
    logic                         LockFail;
`ifdef LOCK_DIALER_RETRY_EN
    logic                         LockReset;
`endif

    modport master (
        output Digit,
        output Enter,
`ifdef LOCK_DIALER_RETRY_EN
        output LockReset,
`endif
        input  LockOpen,
        input  LockFail
    );

    modport slave (
        input  Digit,
        input  Enter,
`ifdef LOCK_DIALER_RETRY_EN
        input  LockReset,
`endif
        output LockOpen,
        output LockFail
    );
endinterface

// File: rtl/lock_dialer_timer.sv
// Loadable down-counter shared by the inter-digit gap and the response wait.
// expire is high while the count sits at 1, i.e. on the last counted cycle.
module lock_dialer_timer #(
    parameter int CNT_W = 5
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_value,
    input  logic             dec,
    output logic             expire
);
    logic [CNT_W-1:0] count_reg;
    logic [CNT_W-1:0] count_next;

    // Load wins over decrement; the count never wraps below zero.
    always_comb begin
        count_next = count_reg;
        if (load) begin
            count_next = load_value;
        end else if (dec && (count_reg != '0)) begin
            count_next = count_reg - CNT_W'(1);
        end
    end

    // Count register.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    assign expire = (count_reg == CNT_W'(1));
endmodule

// File: rtl/lock_dialer.sv
// Keypad lock initiator: on Start, presents the captured code one digit per
// Enter pulse, then waits for Open/Fail with a timeout and reports the result.
// Optional macro LOCK_DIALER_RETRY_EN: up to three automatic retries, each
// preceded by a one-cycle LockReset pulse, counted on RetryCount.
module lock_dialer
    import lock_pkg::*;
#(
    parameter int NUM_DIGITS     = 2,
    parameter int GAP_CYCLES     = 3,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                          Clock,
    input  logic                          Reset,
    input  logic                          Start,
    input  logic [DIGIT_W*NUM_DIGITS-1:0] Code,
    lock_dialer_if.master                 lock,
    output logic                          Busy,
    output logic                          Done,
    output logic                          Success,
    output logic                          TimedOut,
    output logic [2:0]                    State
`ifdef LOCK_DIALER_RETRY_EN
    ,
    output logic [1:0]                    RetryCount
`endif
);
    localparam int CODE_W = DIGIT_W * NUM_DIGITS;
    localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int CNT_W  = $clog2(max_int(GAP_CYCLES, TIMEOUT_CYCLES) + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

    dialer_state_t        state_reg, state_next;
    logic [CODE_W-1:0]    code_reg, code_next;
    logic [IDX_W-1:0]     index_reg, index_next;
    logic [DIGIT_W-1:0]   digit_reg, digit_next;
    logic                 enter_reg, enter_next;
    logic                 busy_reg, busy_next;
    logic                 done_reg, done_next;
    logic                 success_reg, success_next;
    logic                 timed_out_reg, timed_out_next;

    logic                 timer_load;
    logic [CNT_W-1:0]     timer_value;
    logic                 timer_dec;
    logic                 timer_expire;
    logic                 fail_event;
    logic                 timeout_event;

`ifdef LOCK_DIALER_RETRY_EN
    logic [1:0]           retry_reg, retry_next;
    logic                 lock_reset_reg, lock_reset_next;
`endif

    lock_dialer_timer #(
        .CNT_W(CNT_W)
    ) u_timer (
        .Clock      (Clock),
        .Reset      (Reset),
        .load       (timer_load),
        .load_value (timer_value),
        .dec        (timer_dec),
        .expire     (timer_expire)
    );

    // Next-state logic; registered outputs are derived from the next state so
    // they line up with the state they describe.
    always_comb begin
        state_next     = state_reg;
        code_next      = code_reg;
        index_next     = index_reg;
        success_next   = success_reg;
        timed_out_next = timed_out_reg;
        timer_load     = 1'b0;
        timer_value    = '0;
        timer_dec      = 1'b0;
        fail_event     = 1'b0;
        timeout_event  = 1'b0;
`ifdef LOCK_DIALER_RETRY_EN
        retry_next     = retry_reg;
`endif

        case (state_reg)
            IDLE: begin
                if (Start) begin
                    code_next      = Code;
                    index_next     = '0;
                    success_next   = 1'b0;
                    timed_out_next = 1'b0;
`ifdef LOCK_DIALER_RETRY_EN
                    retry_next     = 2'd0;
`endif
                    state_next     = SEND;
                end
            end
            SEND: begin
                if (lock.LockFail) begin
                    fail_event = 1'b1;
                end else if (index_reg == LAST_IDX) begin
                    timer_load  = 1'b1;
                    timer_value = CNT_W'(TIMEOUT_CYCLES);
                    state_next  = WAIT;
                end else begin
                    timer_load  = 1'b1;
                    timer_value = CNT_W'(GAP_CYCLES);
                    state_next  = GAP;
                end
            end
            GAP: begin
                timer_dec = 1'b1;
                if (lock.LockFail) begin
                    fail_event = 1'b1;
                end else if (timer_expire) begin
                    index_next = index_reg + IDX_W'(1);
                    state_next = SEND;
                end
            end
            WAIT: begin
                timer_dec = 1'b1;
                if (lock.LockFail) begin
                    fail_event = 1'b1;
                end else if (lock.LockOpen) begin
                    success_next = 1'b1;
                    state_next   = DONE;
                end else if (timer_expire) begin
                    timeout_event = 1'b1;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
`ifdef LOCK_DIALER_RETRY_EN
            RETRY: begin
                index_next = '0;
                state_next = SEND;
            end
`endif
            default: begin
                state_next = IDLE;
            end
        endcase

        // A failed or silent attempt either retries or finishes the attempt.
        if (fail_event || timeout_event) begin
`ifdef LOCK_DIALER_RETRY_EN
            if (retry_reg != 2'd3) begin
                retry_next = retry_reg + 2'd1;
                index_next = '0;
                state_next = RETRY;
            end else
`endif
            begin
                success_next   = 1'b0;
                timed_out_next = timeout_event;
                state_next     = DONE;
            end
        end

        enter_next = (state_next == SEND);
        digit_next = (state_next == SEND) ? code_next[index_next*DIGIT_W +: DIGIT_W]
                                          : digit_reg;
        busy_next  = (state_next != IDLE);
        done_next  = (state_next == DONE);
`ifdef LOCK_DIALER_RETRY_EN
        lock_reset_next = (state_next == RETRY);
`endif
    end

    // State, code/index and output registers.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_reg     <= IDLE;
            code_reg      <= '0;
            index_reg     <= '0;
            digit_reg     <= '0;
            enter_reg     <= 1'b0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            success_reg   <= 1'b0;
            timed_out_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            code_reg      <= code_next;
            index_reg     <= index_next;
            digit_reg     <= digit_next;
            enter_reg     <= enter_next;
            busy_reg      <= busy_next;
            done_reg      <= done_next;
            success_reg   <= success_next;
            timed_out_reg <= timed_out_next;
        end
    end

`ifdef LOCK_DIALER_RETRY_EN
    // Retry bookkeeping registers.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            retry_reg      <= 2'd0;
            lock_reset_reg <= 1'b0;
        end else begin
            retry_reg      <= retry_next;
            lock_reset_reg <= lock_reset_next;
        end
    end

    assign RetryCount     = retry_reg;
    assign lock.LockReset = lock_reset_reg;
`endif

    assign lock.Digit = digit_reg;
    assign lock.Enter = enter_reg;
    assign Busy       = busy_reg;
    assign Done       = done_reg;
    assign Success    = success_reg;
    assign TimedOut   = timed_out_reg;
    assign State      = state_reg;
endmodule

// File: tb/tb_lock_dialer.sv
// Testbench for lock_dialer: directed and randomized attempts compared against
// a timeline model of the dialing protocol.
module tb_lock_dialer;
    localparam int N = 2;
    localparam int G = 3;
    localparam int T = 16;
    localparam int L = 1 + (N - 1) * (G + 1);   // cycle of the last Enter after Start

    logic           Clock = 1'b0;
    logic           Reset;
    logic           Start;
    logic [4*N-1:0] Code;
    logic           Busy, Done, Success, TimedOut;
    logic [2:0]     State;
`ifdef LOCK_DIALER_RETRY_EN
    logic [1:0]     RetryCount;
`endif

    int checks   = 0;
    int failures = 0;

    lock_dialer_if lk();

    lock_dialer #(
        .NUM_DIGITS     (N),
        .GAP_CYCLES     (G),
        .TIMEOUT_CYCLES (T)
    ) dut (
        .Clock      (Clock),
        .Reset      (Reset),
        .Start      (Start),
        .Code       (Code),
        .lock       (lk),
        .Busy       (Busy),
        .Done       (Done),
        .Success    (Success),
        .TimedOut   (TimedOut),
`ifdef LOCK_DIALER_RETRY_EN
        .RetryCount (RetryCount),
`endif
        .State      (State)
    );

    always #5 Clock = ~Clock;

    // Expected outcome of one attempt. Cycle 0 is the cycle Start is high;
    // fail_at/open_at are the first cycles the response is held high (-1: never).
    function automatic void model(input int fail_at, input int open_at,
                                  output int n_enter, output int done_rel,
                                  output bit succ, output bit tmo);
        for (int c = 1; c <= L + T; c++) begin
            if (fail_at >= 0 && c >= fail_at) begin
                done_rel = c + 1;
                succ     = 1'b0;
                tmo      = 1'b0;
                n_enter  = (c <= L) ? ((c - 1) / (G + 1) + 1) : N;
                return;
            end
            if (c > L && open_at >= 0 && c >= open_at) begin
                done_rel = c + 1;
                succ     = 1'b1;
                tmo      = 1'b0;
                n_enter  = N;
                return;
            end
        end
        done_rel = L + T + 1;
        succ     = 1'b0;
        tmo      = 1'b1;
        n_enter  = N;
    endfunction

    task automatic run_attempt(input logic [4*N-1:0] code, input int fail_at,
                               input int open_at, input bit hold_start, input string name);
        int          n_exp, done_exp, done_at;
        bit          s_exp, t_exp;
        int          times[$];
        logic [3:0]  digs[$];
        logic [3:0]  dig_exp;
        model(fail_at, open_at, n_exp, done_exp, s_exp, t_exp);
        done_at = -1;
        @(negedge Clock);
        Code = code;
        Start = 1'b1;
        lk.LockFail = 1'b0;
        lk.LockOpen = 1'b0;
        for (int rel = 1; rel <= 60 && done_at < 0; rel++) begin
            @(negedge Clock);
            if (lk.Enter) begin
                times.push_back(rel);
                digs.push_back(lk.Digit);
            end
            if (Done) done_at = rel;
            Start = hold_start;
            lk.LockFail = (fail_at >= 0 && rel >= fail_at);
            lk.LockOpen = (open_at >= 0 && rel >= open_at);
        end
        checks++;
        if (done_at !== done_exp) begin
            failures++;
            $display("FAIL %s done_cycle: got %0d expected %0d", name, done_at, done_exp);
        end
        checks++;
        if ({Success, TimedOut} !== {s_exp, t_exp}) begin
            failures++;
            $display("FAIL %s result: got Success=%b TimedOut=%b expected Success=%b TimedOut=%b",
                     name, Success, TimedOut, s_exp, t_exp);
        end
        checks++;
        if (times.size() != n_exp) begin
            failures++;
            $display("FAIL %s enter_count: got %0d expected %0d", name, times.size(), n_exp);
        end
        for (int i = 0; i < times.size() && i < n_exp; i++) begin
            dig_exp = code[4*i +: 4];
            checks++;
            if (times[i] != 1 + i * (G + 1) || digs[i] !== dig_exp) begin
                failures++;
                $display("FAIL %s enter%0d: got cycle %0d digit %h expected cycle %0d digit %h",
                         name, i, times[i], digs[i], 1 + i * (G + 1), dig_exp);
            end
        end
        // Cycle after Done: back in IDLE, result held.
        @(negedge Clock);
        Start = 1'b0;
        lk.LockFail = 1'b0;
        lk.LockOpen = 1'b0;
        checks++;
        if ({Busy, Done, Success, TimedOut} !== {1'b0, 1'b0, s_exp, t_exp}) begin
            failures++;
            $display("FAIL %s after_done: got Busy=%b Done=%b Success=%b TimedOut=%b expected 0 0 %b %b",
                     name, Busy, Done, Success, TimedOut, s_exp, t_exp);
        end
        // Start high during DONE must not have launched a new attempt.
        @(negedge Clock);
        checks++;
        if (State !== 3'd0 || Busy !== 1'b0) begin
            failures++;
            $display("FAIL %s idle_after: got State=%0d Busy=%b expected State=0 Busy=0",
                     name, State, Busy);
        end
        $display("attempt %s code=%h fail_at=%0d open_at=%0d done=%0d enters=%0d Success=%b TimedOut=%b",
                 name, code, fail_at, open_at, done_at, times.size(), Success, TimedOut);
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        Start = 1'b0;
        Code = '0;
        lk.LockFail = 1'b0;
        lk.LockOpen = 1'b0;
        repeat (2) @(negedge Clock);
        checks++;
        if ({lk.Digit, lk.Enter, Busy, Done, Success, TimedOut, State} !== 12'd0) begin
            failures++;
            $display("FAIL reset_state: got Digit=%h Enter=%b Busy=%b Done=%b Success=%b TimedOut=%b State=%0d expected all 0",
                     lk.Digit, lk.Enter, Busy, Done, Success, TimedOut, State);
        end
        Reset = 1'b0;
        $display("reset check done");
    endtask

    task automatic test_reset_mid_gap();
        int bad;
        @(negedge Clock);
        Code = 8'h32;
        Start = 1'b1;
        repeat (2) @(negedge Clock);          // cycle 2: GAP, Start still held
        checks++;
        if (State !== 3'd2 || lk.Enter !== 1'b0) begin
            failures++;
            $display("FAIL held_start_gap: got State=%0d Enter=%b expected State=2 Enter=0", State, lk.Enter);
        end
        @(negedge Clock);                      // cycle 3: assert Reset
        Reset = 1'b1;
        @(negedge Clock);
        Reset = 1'b0;
        Start = 1'b0;
        checks++;
        if ({lk.Digit, lk.Enter, Busy, Done, Success, TimedOut, State} !== 12'd0) begin
            failures++;
            $display("FAIL reset_mid_gap: got Digit=%h Enter=%b Busy=%b Done=%b Success=%b TimedOut=%b State=%0d expected all 0",
                     lk.Digit, lk.Enter, Busy, Done, Success, TimedOut, State);
        end
        bad = 0;
        for (int i = 0; i < 25; i++) begin
            @(negedge Clock);
            if (Done || lk.Enter || Busy) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL reset_no_done: got %0d active cycles expected 0", bad);
        end
        $display("reset mid-gap done");
    endtask

`ifdef LOCK_DIALER_RETRY_EN
    task automatic test_retry();
        int resets, dones, done_at;
        resets = 0;
        dones = 0;
        done_at = -1;
        @(negedge Clock);
        Code = 8'h32;
        Start = 1'b1;
        for (int rel = 1; rel <= 150; rel++) begin
            @(negedge Clock);
            Start = 1'b0;
            if (lk.LockReset) resets++;
            if (Done) begin
                dones++;
                done_at = rel;
                checks++;
                if (TimedOut !== 1'b1 || Success !== 1'b0 || RetryCount !== 2'd3) begin
                    failures++;
                    $display("FAIL retry_result: got TimedOut=%b Success=%b RetryCount=%0d expected 1 0 3",
                             TimedOut, Success, RetryCount);
                end
            end
        end
        checks++;
        if (resets != 3 || dones != 1 || done_at != 4 * (L + T + 1)) begin
            failures++;
            $display("FAIL retry_counts: got resets=%0d dones=%0d done=%0d expected 3 1 %0d",
                     resets, dones, done_at, 4 * (L + T + 1));
        end
        $display("retry attempt resets=%0d dones=%0d done=%0d", resets, dones, done_at);
    endtask
`endif

    task automatic test_random();
        int fa, oa, sel;
        for (int k = 0; k < 10; k++) begin
            sel = $urandom_range(0, 3);
            fa = (sel == 0 || sel == 2) ? $urandom_range(1, L + T) : -1;
            oa = (sel == 1 || sel == 2) ? $urandom_range(1, L + T) : -1;
            run_attempt(8'($urandom), fa, oa, 1'($urandom), "random");
        end
    endtask

    initial begin
        test_reset();
`ifdef LOCK_DIALER_RETRY_EN
        test_retry();
        run_attempt(8'h32, -1, L + 2, 1'b0, "retry_open");
`else
        run_attempt(8'h32, -1, L + 2, 1'b0, "open");
        run_attempt(8'h35, L + 2, -1, 1'b0, "fail_wait");
        run_attempt(8'h32, 3, -1, 1'b0, "fail_gap");
        run_attempt(8'h47, 1, -1, 1'b0, "fail_send");
        run_attempt(8'h9a, -1, -1, 1'b0, "timeout");
        run_attempt(8'h61, L + 3, L + 3, 1'b0, "both");
        run_attempt(8'hc4, -1, L + T, 1'b1, "start_held");
        test_reset_mid_gap();
        test_random();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/lock_dialer.md
Name: lock_dialer

Overview:
Initiator side of the keypad lock interface. On a Start request it presents a stored multi-digit code to a lock, one digit per Enter pulse. It then waits for the lock's Open/Fail response, with a timeout, and reports the result. It drives Digit/Enter of a combination-lock block and consumes that block's Open/Fail outputs. Used for self-test and automated unlock sequences.

Parameters:
NUM_DIGITS, 2, number of 4-bit digits sent per attempt (>=1)
GAP_CYCLES, 3, Enter-low cycles between consecutive digit pulses (>=1)
TIMEOUT_CYCLES, 16, cycles to wait for Open/Fail after the last digit (>=1)

Ports:
Clock  in  1  system clock
Reset  in  1  synchronous, active-high reset
Start  in  1  begin an attempt; sampled only in IDLE
Code  in  4*NUM_DIGITS  code; digit 0 in bits [3:0], sent first
Digit  out  4  digit presented to the lock
Enter  out  1  one-cycle strobe qualifying Digit
LockOpen  in  1  lock Open output
LockFail  in  1  lock Fail output
Busy  out  1  high in every state except IDLE
Done  out  1  one-cycle pulse when an attempt finishes
Success  out  1  last attempt opened the lock; held until next Start
TimedOut  out  1  last attempt got no response; held until next Start
State  out  3  current FSM state encoding

Behaviour:
- Interface decided: reset Reset, synchronous, active-high; clock Clock.
- Reset: state IDLE; Digit=0, Enter=0, Busy=0, Done=0, Success=0, TimedOut=0; internal code register, index and counter cleared. Reset mid-attempt aborts immediately with no Done pulse.
- All outputs are registered.
- States: IDLE=3'd0, SEND=3'd1, GAP=3'd2, WAIT=3'd3, DONE=3'd4; codes 5-7 recover to IDLE.
- IDLE: Start=1 captures Code into the internal register, clears index, clears Success/TimedOut, and moves to SEND. Start in any other state is ignored.
- SEND (exactly 1 cycle):
  - Digit=code[index], Enter=1.
  - If index==NUM_DIGITS-1, load counter=TIMEOUT_CYCLES and go to WAIT.
  - Otherwise load counter=GAP_CYCLES and go to GAP.
- GAP: Enter=0 and Digit holds its value. The counter decrements each cycle. When the counter reaches 1: index++, go to SEND. Exactly GAP_CYCLES Enter-low cycles separate pulses.
- WAIT: the counter decrements each cycle.
  - LockFail=1 → DONE with Success=0.
  - Else LockOpen=1 → DONE with Success=1.
  - Else, when the counter expires → DONE with TimedOut=1.
  - LockFail has priority over LockOpen when both are high.
- Early abort: LockFail=1 during SEND or GAP → DONE with Success=0; remaining digits are not sent.
- DONE (1 cycle): Done=1, Enter=0, then go to IDLE. Success/TimedOut are stable from the Done cycle until the next accepted Start.
- Start high in the same cycle as DONE is ignored; it must be high in IDLE to be accepted.
- Width rules:
  - index is $clog2(NUM_DIGITS) bits (min 1).
  - counter is $clog2(max(GAP_CYCLES,TIMEOUT_CYCLES)+1) bits.
  - No wrap: index never exceeds NUM_DIGITS-1.

Optional Feature:
Macro LOCK_DIALER_RETRY_EN.
- Defined:
  - Adds output LockReset (1 bit) and output RetryCount (2 bits).
  - On a Fail or timeout result with RetryCount<3: LockReset is pulsed for 1 cycle and RetryCount increments.
  - After the pulse, the dialer re-enters SEND with index=0. No Done pulse is issued between retries.
  - Done pulses only on success or on the final failure.
  - RetryCount clears on Start and on Reset.
- Not defined: no extra ports; a single attempt is made, as described above.

Decomposition:
- Shared package lock_pkg holds the state encoding constants (IDLE..DONE, plus the lock's LOCKED/OK/BAD1/BAD2/OPEN), the digit width constant DIGIT_W=4, and the default code constants DEFAULT_DIGIT_1=4'h2 and DEFAULT_DIGIT_2=4'h3.
- One natural sub-module, lock_dialer_timer: loadable down-counter with expire flag, used for both GAP and WAIT.
- FSM and digit selection remain in lock_dialer.

Test Plan:
- Reset then Code=8'h32, Start → Enter pulses with Digit=2 then, 3 gap cycles later, Digit=3. LockOpen asserted 2 cycles after → Done pulse, Success=1, TimedOut=0, Busy low the next cycle.
- Code=8'h35, lock asserts LockFail 2 cycles after second Enter → Done, Success=0, TimedOut=0.
- LockFail raised during GAP after first digit → Done 1 cycle later, only one Enter pulse observed.
- Neither response after last digit → Done exactly 16 cycles later, TimedOut=1; LockOpen+LockFail together → Success=0.
- Start held high during an attempt and Reset asserted mid-GAP → second Start ignored; after Reset all outputs 0, State=0, no Done.
- With LOCK_DIALER_RETRY_EN, permanent timeout → three LockReset pulses, RetryCount=3, a single final Done with TimedOut=1.
